// File: rtl/arm_decode_stage_pkg.sv
// Shared instruction types for the ARM decode stage: field enums, the decoded
// payload struct and the pure decode function used on accept.
package arm_decode_stage_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned REG_W   = 4;
  localparam int unsigned NZCV_W  = 4;

  typedef enum logic [3:0] {
    COND_EQ = 4'd0,  COND_NE = 4'd1,  COND_CS = 4'd2,  COND_CC = 4'd3,
    COND_MI = 4'd4,  COND_PL = 4'd5,  COND_VS = 4'd6,  COND_VC = 4'd7,
    COND_HI = 4'd8,  COND_LS = 4'd9,  COND_GE = 4'd10, COND_LT = 4'd11,
    COND_GT = 4'd12, COND_LE = 4'd13, COND_AL = 4'd14, COND_NV = 4'd15
  } cond_e;

  typedef enum logic [3:0] {
    ALU_AND = 4'd0,  ALU_EOR = 4'd1,  ALU_SUB = 4'd2,  ALU_RSB = 4'd3,
    ALU_ADD = 4'd4,  ALU_ADC = 4'd5,  ALU_SBC = 4'd6,  ALU_RSC = 4'd7,
    ALU_TST = 4'd8,  ALU_TEQ = 4'd9,  ALU_CMP = 4'd10, ALU_CMN = 4'd11,
    ALU_ORR = 4'd12, ALU_MOV = 4'd13, ALU_BIC = 4'd14, ALU_MVN = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    SHIFT_LSL = 2'd0, SHIFT_LSR = 2'd1, SHIFT_ASR = 2'd2, SHIFT_ROR = 2'd3
  } shift_type_e;

  typedef enum logic {
    OFFSET_REG = 1'b0,
    OFFSET_IMM = 1'b1
  } offset_type_e;

  typedef enum logic {
    PSR_CPSR = 1'b0,
    PSR_SPSR = 1'b1
  } source_psr_e;

  typedef enum logic {
    OP2_SHIFT_IMM = 1'b0,
    OP2_SHIFT_REG = 1'b1
  } op2_shift_e;

  typedef enum logic [2:0] {
    CLASS_DP     = 3'd0,
    CLASS_MRS    = 3'd1,
    CLASS_MSR    = 3'd2,
    CLASS_BRANCH = 3'd3,
    CLASS_BX     = 3'd4,
    CLASS_SDT    = 3'd5,
    CLASS_UNDEF  = 3'd7
  } instr_class_e;

  typedef struct packed {
    instr_class_e     cls;
    cond_e            cond;
    alu_op_e          alu_op;
    logic             set_flags;
    logic [REG_W-1:0] rn;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rm;
    logic [REG_W-1:0] rs;
    offset_type_e     op2_kind;
    logic [31:0]      imm;
    shift_type_e      shift_type;
    op2_shift_e       shift_src;
    logic [4:0]       shift_amt;
    source_psr_e      psr;
    logic             link;
    logic [31:0]      br_offset;
  } decoded_t;

  // 8-bit immediate rotated right by twice the 4-bit rotate field
  function automatic logic [31:0] rot_imm(input logic [11:0] op2);
    logic [31:0] base;
    logic [4:0]  rot;
    base = 32'(op2[7:0]);
    rot  = {op2[11:8], 1'b0};
    return (base >> rot) | (base << (6'd32 - 6'(rot)));
  endfunction

  // Fill the shifter-operand fields shared by DP and MSR
  function automatic decoded_t with_op2(input decoded_t d_in, input logic imm_sel,
                                        input logic [11:0] op2);
    decoded_t d;
    d = d_in;
    d.op2_kind = offset_type_e'(imm_sel);
    if (imm_sel) begin
      d.imm = rot_imm(op2);
    end else begin
      d.rm         = op2[3:0];
      d.shift_type = shift_type_e'(op2[6:5]);
      d.shift_src  = op2_shift_e'(op2[4]);
      if (op2[4]) begin
        d.rs = op2[11:8];
      end else begin
        d.shift_amt = op2[11:7];
      end
    end
    return d;
  endfunction

  // Full decode; fields irrelevant to the class stay zero
  function automatic decoded_t decode_instr(input logic [INSTR_W-1:0] instr);
    decoded_t d;
    d      = '0;
    d.cond = cond_e'(instr[31:28]);
    if (instr[27:4] == 24'h12FFF1) begin
      d.cls = CLASS_BX;
      d.rm  = instr[3:0];
    end else if (instr[27:25] == 3'b101) begin
      d.cls       = CLASS_BRANCH;
      d.link      = instr[24];
      d.br_offset = {{6{instr[23]}}, instr[23:0], 2'b00};
    end else if (instr[27:23] == 5'b00010 && instr[21:16] == 6'b001111 &&
                 instr[11:0] == 12'h000) begin
      d.cls = CLASS_MRS;
      d.psr = source_psr_e'(instr[22]);
      d.rd  = instr[15:12];
    end else if (instr[27:26] == 2'b00 && instr[24:23] == 2'b10 &&
                 instr[21] && !instr[20]) begin
      d     = with_op2(d, instr[25], instr[11:0]);
      d.cls = CLASS_MSR;
      d.psr = source_psr_e'(instr[22]);
    end else if (instr[27:26] == 2'b00) begin
      d           = with_op2(d, instr[25], instr[11:0]);
      d.cls       = CLASS_DP;
      d.alu_op    = alu_op_e'(instr[24:21]);
      // Compare/test opcodes only exist to set flags
      d.set_flags = instr[20] || (instr[24:23] == 2'b10);
      d.rn        = instr[19:16];
      d.rd        = instr[15:12];
    end else if (instr[27:26] == 2'b01) begin
      d.cls = CLASS_SDT;
    end else begin
      d.cls = CLASS_UNDEF;
    end
    return d;
  endfunction

endpackage

// File: rtl/arm_decode_stage_if.sv
// Fetch-side and execute-side handshakes of the ARM decode stage.
interface arm_decode_stage_if #(
  parameter int unsigned PC_WIDTH = 32
);
  import arm_decode_stage_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [INSTR_W-1:0]  in_instr;
  logic [PC_WIDTH-1:0] in_pc;

  logic                out_valid;
  logic                out_ready;
  logic [PC_WIDTH-1:0] out_pc;
  logic [3:0]          out_cond;
  logic                out_cond_pass;
  logic [2:0]          out_class;
  logic [3:0]          out_alu_op;
  logic                out_set_flags;
  logic [REG_W-1:0]    out_rn;
  logic [REG_W-1:0]    out_rd;
  logic [REG_W-1:0]    out_rm;
  logic [REG_W-1:0]    out_rs;
  logic                out_op2_kind;
  logic [31:0]         out_imm;
  logic [1:0]          out_shift_type;
  logic                out_shift_src;
  logic [4:0]          out_shift_amt;
  logic                out_psr;
  logic                out_link;
  logic [31:0]         out_br_offset;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_cond, out_cond_pass, out_class,
           out_alu_op, out_set_flags, out_rn, out_rd, out_rm, out_rs,
           out_op2_kind, out_imm, out_shift_type, out_shift_src, out_shift_amt,
           out_psr, out_link, out_br_offset
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_cond, out_cond_pass, out_class,
           out_alu_op, out_set_flags, out_rn, out_rd, out_rm, out_rs,
           out_op2_kind, out_imm, out_shift_type, out_shift_src, out_shift_amt,
           out_psr, out_link, out_br_offset
  );

endinterface

// File: rtl/arm_decode_stage_cond_check.sv
// ARM condition-code evaluation against NZCV flags; shared with execute.
module cond_check
  import arm_decode_stage_pkg::*;
(
  input  cond_e             cond_i,
  input  logic [NZCV_W-1:0] nzcv_i,
  output logic              pass_o
);

  logic n, z, c, v;
  assign {n, z, c, v} = nzcv_i;

  // Condition table lookup
  always_comb begin
    pass_o = 1'b0;
    case (cond_i)
      COND_EQ: pass_o = z;
      COND_NE: pass_o = !z;
      COND_CS: pass_o = c;
      COND_CC: pass_o = !c;
      COND_MI: pass_o = n;
      COND_PL: pass_o = !n;
      COND_VS: pass_o = v;
      COND_VC: pass_o = !v;
      COND_HI: pass_o = c && !z;
      COND_LS: pass_o = !c || z;
      COND_GE: pass_o = (n == v);
      COND_LT: pass_o = (n != v);
      COND_GT: pass_o = !z && (n == v);
      COND_LE: pass_o = z || (n != v);
      COND_AL: pass_o = 1'b1;
      COND_NV: pass_o = 1'b0;
      default: pass_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/arm_decode_stage.sv
// ARM decode stage: decodes on accept into a registered output slot.
// Build option ARM_DECODE_SKID_EN adds a skid entry so in_ready is registered;
// without it in_ready is !out_valid || out_ready.
module arm_decode_stage
  import arm_decode_stage_pkg::*;
#(
  parameter int unsigned PC_WIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic [NZCV_W-1:0] flags_nzcv,
  arm_decode_stage_if.slave bus
);

  decoded_t            in_dec_c;
  logic                accept_c;
  logic                pop_c;

  decoded_t            out_q, out_d;
  logic [PC_WIDTH-1:0] out_pc_q, out_pc_d;
  logic                out_valid_q, out_valid_d;

  assign in_dec_c = decode_instr(bus.in_instr);
  assign accept_c = bus.in_valid && bus.in_ready;
  assign pop_c    = out_valid_q && bus.out_ready;

`ifdef ARM_DECODE_SKID_EN
  decoded_t            skid_q, skid_d;
  logic [PC_WIDTH-1:0] skid_pc_q, skid_pc_d;
  logic                skid_valid_q, skid_valid_d;
  logic                in_ready_q, in_ready_d;

  // Ready comes from a flop, so out_ready never reaches it combinationally
  assign bus.in_ready = in_ready_q && !reset && !flush;

  // Refill the output slot from the skid entry first, then from fetch
  always_comb begin
    out_valid_d  = out_valid_q;
    out_d        = out_q;
    out_pc_d     = out_pc_q;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;
    skid_pc_d    = skid_pc_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      out_d        = '0;
      out_pc_d     = '0;
      skid_valid_d = 1'b0;
      skid_d       = '0;
      skid_pc_d    = '0;
    end else if (!out_valid_q || pop_c) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_d        = skid_q;
        out_pc_d     = skid_pc_q;
        skid_valid_d = 1'b0;
        skid_d       = '0;
        skid_pc_d    = '0;
      end else if (accept_c) begin
        out_valid_d = 1'b1;
        out_d       = in_dec_c;
        out_pc_d    = bus.in_pc;
      end else begin
        out_valid_d = 1'b0;
        out_d       = '0;
        out_pc_d    = '0;
      end
    end else if (accept_c) begin
      skid_valid_d = 1'b1;
      skid_d       = in_dec_c;
      skid_pc_d    = bus.in_pc;
    end
    in_ready_d = !skid_valid_d;
  end

  // Skid entry and registered ready
  always_ff @(posedge clk) begin
    if (reset) begin
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
      skid_pc_q    <= '0;
      in_ready_q   <= 1'b1;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_q       <= skid_d;
      skid_pc_q    <= skid_pc_d;
      in_ready_q   <= in_ready_d;
    end
  end
`else
  // Accept whenever the single output slot is free or draining this cycle
  assign bus.in_ready = !reset && !flush && (!out_valid_q || bus.out_ready);

  // Load on accept, clear on drain, otherwise hold
  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    out_pc_d    = out_pc_q;
    if (flush) begin
      out_valid_d = 1'b0;
      out_d       = '0;
      out_pc_d    = '0;
    end else if (accept_c) begin
      out_valid_d = 1'b1;
      out_d       = in_dec_c;
      out_pc_d    = bus.in_pc;
    end else if (pop_c) begin
      out_valid_d = 1'b0;
      out_d       = '0;
      out_pc_d    = '0;
    end
  end
`endif

  // Output slot registers
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      out_pc_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      out_pc_q    <= out_pc_d;
    end
  end

  cond_check u_cond_check (
    .cond_i (out_q.cond),
    .nzcv_i (flags_nzcv),
    .pass_o (bus.out_cond_pass)
  );

  assign bus.out_valid      = out_valid_q;
  assign bus.out_pc         = out_pc_q;
  assign bus.out_cond       = out_q.cond;
  assign bus.out_class      = out_q.cls;
  assign bus.out_alu_op     = out_q.alu_op;
  assign bus.out_set_flags  = out_q.set_flags;
  assign bus.out_rn         = out_q.rn;
  assign bus.out_rd         = out_q.rd;
  assign bus.out_rm         = out_q.rm;
  assign bus.out_rs         = out_q.rs;
  assign bus.out_op2_kind   = out_q.op2_kind;
  assign bus.out_imm        = out_q.imm;
  assign bus.out_shift_type = out_q.shift_type;
  assign bus.out_shift_src  = out_q.shift_src;
  assign bus.out_shift_amt  = out_q.shift_amt;
  assign bus.out_psr        = out_q.psr;
  assign bus.out_link       = out_q.link;
  assign bus.out_br_offset  = out_q.br_offset;

endmodule
